// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window front end.
package sobel_pkg;

  localparam int K_MAX = 7;
  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int win_idx(
    input int r,
    input int c,
    input int k,
    input int dw
  );
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// One image line of pixel history, read before write at the same address.
module line_buffer #(
  parameter int DEPTH = 100,
  parameter int DW    = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/sliding_window_gen.sv
// KxK raster window generator with line buffers and a registered output.
module sliding_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(pixel_t),
  parameter int K          = 3,
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_sof,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [K*K*DATA_WIDTH-1:0]     out_window,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          out_eof,
  output logic                          sync_err
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int WW = K * K * DATA_WIDTH;

  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [WW-1:0]         r_win;
  logic [WW-1:0]         w_win_nxt;
  logic [XW-1:0]         w_ex;
  logic [YW-1:0]         w_ey;
  logic                  w_acc;
  logic                  w_done;
  logic                  w_last_x;
  logic                  w_last_y;
  logic [DATA_WIDTH-1:0] w_lb_rd [K-1];
  logic [DATA_WIDTH-1:0] w_lb_wd [K-1];

  assign in_ready = rst_n & (~out_valid | out_ready);
  assign w_acc    = in_valid & in_ready;

  // sof forces the accepted pixel to (0,0) before any gating
  assign w_ex     = in_sof ? '0 : r_x;
  assign w_ey     = in_sof ? '0 : r_y;
  assign w_last_x = (w_ex == XW'(IMG_WIDTH - 1));
  assign w_last_y = (w_ey == YW'(IMG_HEIGHT - 1));
  assign w_done   = (w_ey >= YW'(K - 1)) && (w_ex >= XW'(K - 1));

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign w_lb_wd[i] = in_data;
    end else begin : g_chain
      assign w_lb_wd[i] = w_lb_rd[i-1];
    end
    line_buffer #(
      .DEPTH(IMG_WIDTH),
      .DW   (DATA_WIDTH),
      .AW   (XW)
    ) u_lb (
      .clk  (clk),
      .en   (w_acc),
      .addr (w_ex),
      .wdata(w_lb_wd[i]),
      .rdata(w_lb_rd[i])
    );
  end

  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_win_nxt[win_idx(r, c, K, DATA_WIDTH) +: DATA_WIDTH] =
          r_win[win_idx(r, c + 1, K, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      w_win_nxt[win_idx(K - 2 - i, K - 1, K, DATA_WIDTH) +: DATA_WIDTH] =
        w_lb_rd[i];
    end
    w_win_nxt[win_idx(K - 1, K - 1, K, DATA_WIDTH) +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_win      <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_eof    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_win <= w_win_nxt;
        if (in_sof && (r_x != '0 || r_y != '0)) sync_err <= 1'b1;
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : w_ey + YW'(1);
        end else begin
          r_x <= w_ex + XW'(1);
          r_y <= w_ey;
        end
      end
      if (w_acc && w_done) begin
        out_valid  <= 1'b1;
        out_window <= w_win_nxt;
        out_row    <= w_ey - YW'(K - 1);
        out_col    <= w_ex - XW'(K - 1);
        out_eof    <= w_last_x & w_last_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Scoreboard bench for sliding_window_gen: 3x3 on 8x6 and 5x5 on 7x5.
module tb_sliding_window_gen;

  typedef logic [199:0] wv_t;
  typedef struct {
    wv_t win;
    int  row;
    int  col;
    bit  eof;
    bit  lat;
    time t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_in_valid, a_in_ready, a_in_sof;
  logic        a_out_valid, a_out_ready, a_out_eof, a_sync_err;
  logic [7:0]  a_in_data;
  logic [71:0] a_out_window;
  logic [2:0]  a_out_row, a_out_col;

  logic         b_rst_n, b_in_valid, b_in_ready, b_in_sof;
  logic         b_out_valid, b_out_ready, b_out_eof, b_sync_err;
  logic [7:0]   b_in_data;
  logic [199:0] b_out_window;
  logic [2:0]   b_out_row, b_out_col;

  sliding_window_gen #(
    .DATA_WIDTH(8), .K(3), .IMG_WIDTH(8), .IMG_HEIGHT(6)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sof(a_in_sof),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_window(a_out_window), .out_row(a_out_row),
    .out_col(a_out_col), .out_eof(a_out_eof),
    .sync_err(a_sync_err)
  );

  sliding_window_gen #(
    .DATA_WIDTH(8), .K(5), .IMG_WIDTH(7), .IMG_HEIGHT(5)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sof(b_in_sof),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_window(b_out_window), .out_row(b_out_row),
    .out_col(b_out_col), .out_eof(b_out_eof),
    .sync_err(b_sync_err)
  );

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_win_a = 0;
  int n_win_b = 0;

  task automatic check(input string name, input wv_t act, input wv_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Window at top-left (row,col) of a frame whose pixel is y*16+x
  function automatic wv_t exp_win(input int row, input int col, input int k);
    wv_t w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        w[(r*k+c)*8 +: 8] = 8'((row + r) * 16 + col + c);
    return w;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      n_win_a++;
      if (qa.size() == 0) begin
        check("a_unexpected_window", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_window", a_out_window, e.win);
        check("a_row_col_eof", {a_out_row, a_out_col, a_out_eof},
              {3'(e.row), 3'(e.col), e.eof});
        if (e.lat) check("a_latency", $time - e.t, 5);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      n_win_b++;
      if (qb.size() == 0) begin
        check("b_unexpected_window", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_window", b_out_window, e.win);
        check("b_row_col_eof", {b_out_row, b_out_col, b_out_eof},
              {3'(e.row), 3'(e.col), e.eof});
        if (e.lat) check("b_latency", $time - e.t, 5);
      end
    end
  end

  task automatic send_a(input int y, input int x, input bit sof,
                        input int gap, input bit lat);
    int n;
    if (gap > 0) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_sof   = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = 8'(y * 16 + x);
    a_in_sof   = sof;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!a_in_ready && n < 300);
    if (!a_in_ready) begin
      check("a_accept_timeout", 0, 1);
      return;
    end
    if (y >= 2 && x >= 2)
      qa.push_back('{exp_win(y - 2, x - 2, 3), y - 2, x - 2,
                     (y == 5 && x == 7), lat, $time});
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_sof   = 1'b0;
    end
  endtask

  task automatic frame_a(input bit rnd, input bit lat);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        send_a(y, x, (y == 0 && x == 0),
               rnd ? int'($urandom_range(0, 2)) : 0, lat);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int base;
    wv_t w0;
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_sof = 1'b0;
    a_in_data = '0; a_out_ready = 1'b1;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_sof = 1'b0;
    b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", a_out_valid, 0);
    check("reset_window", a_out_window, 0);
    check("reset_row_col_eof", {a_out_row, a_out_col, a_out_eof}, 0);
    check("reset_sync_err", a_sync_err, 0);
    check("reset_in_ready", a_in_ready, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // full frame at full throughput
    base = n_win_a;
    frame_a(0, 1);
    idle_a(3);
    check("t1_count", n_win_a - base, 24);

    // downstream stall while a window is held
    base = n_win_a;
    fork
      frame_a(0, 0);
      begin
        int n;
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!a_out_valid && n < 100);
        check("t2_stall_valid", a_out_valid, 1);
        w0 = a_out_window;
        repeat (5) begin
          @(negedge clk);
          check("t2_stall_in_ready", a_in_ready, 0);
          check("t2_stall_window", a_out_window, w0);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    idle_a(3);
    check("t2_count", n_win_a - base, 24);

    // resync at counter position (3,4)
    for (int i = 0; i < 3 * 8 + 4; i++)
      send_a(i / 8, i % 8, (i == 0), 0, 0);
    idle_a(1);
    check("t3_no_err_before", a_sync_err, 0);
    frame_a(0, 1);
    idle_a(3);
    check("t3_sync_err_sticky", a_sync_err, 1);

    // reset mid-frame with a window still in the output register
    for (int i = 0; i < 3 * 8 + 6; i++)
      send_a(i / 8, i % 8, (i == 0), 0, 0);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_rst_n    = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    check("t4_valid_after_rst", a_out_valid, 0);
    check("t4_sync_err_after_rst", a_sync_err, 0);
    check("t4_queue_drained", qa.size(), 0);
    base = n_win_a;
    frame_a(0, 1);
    idle_a(3);
    check("t4_count", n_win_a - base, 24);

    // two back-to-back frames with random gaps
    base = n_win_a;
    frame_a(1, 0);
    frame_a(1, 0);
    idle_a(5);
    check("t5_count", n_win_a - base, 48);
    check("t5_sync_err", a_sync_err, 0);

    // K=5 on a 7x5 frame
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = 8'((i / 7) * 16 + i % 7);
      b_in_sof   = (i == 0);
      @(posedge clk);
      check("b_in_ready", b_in_ready, 1);
      if (i / 7 >= 4 && i % 7 >= 4)
        qb.push_back('{exp_win(0, i % 7 - 4, 5), 0, i % 7 - 4,
                       (i == 34), 1, $time});
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_sof   = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_count", n_win_b, 3);
    check("t6_queue_empty", qb.size(), 0);
    check("final_queue_empty", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
